// File: rtl/adda_pkg.sv
// ============================================================================
// Module      : adda_pkg
// Description : Shared constants for the AD/DA streaming controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adda_pkg;

  localparam int ADDA_DATA_W = 8;
  localparam int ADDA_DIV_W  = 8;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_INV  = 2'd1;
  localparam logic [1:0] MODE_RAMP = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

endpackage

`default_nettype wire

// File: rtl/adda_clk_div.sv
// ============================================================================
// Module      : adda_clk_div
// Description : Programmable half-period divider producing the ADC clock and
//               a strobe on the cycle whose edge takes the clock 1->0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adda_clk_div
  import adda_pkg::*;
#(
  parameter int DIV_W = ADDA_DIV_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_ad_clk,
  output logic             o_fall
);

  logic [DIV_W-1:0] r_ctr;
  logic [DIV_W-1:0] r_div_lat;
  logic             r_ad_clk;
  logic             w_wrap;

  assign w_wrap = (r_ctr == r_div_lat);

  // The divisor is only reloaded on a wrap, so a half-period in flight always
  // finishes with the length it started with.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ctr     <= '0;
      r_div_lat <= i_div;
      r_ad_clk  <= 1'b0;
    end else if (w_wrap) begin
      r_ctr     <= '0;
      r_div_lat <= i_div;
      r_ad_clk  <= ~r_ad_clk;
    end else begin
      r_ctr     <= r_ctr + 1'b1;
    end
  end

  assign o_ad_clk = r_ad_clk;
  assign o_fall   = w_wrap & r_ad_clk;

endmodule

`default_nettype wire

// File: rtl/adda_stream_ctrl.sv
// ============================================================================
// Module      : adda_stream_ctrl
// Description : ADC->DAC streaming controller: clock pair, capture, mode mux
//               (pass/invert/ramp/hold) and peak-hold LED level.
//               Define ADDA_AVG_EN for a 4-tap moving average in pass/invert.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adda_stream_ctrl
  import adda_pkg::*;
#(
  parameter int DATA_W   = ADDA_DATA_W,
  parameter int DIV_W    = ADDA_DIV_W,
  parameter int DECAY_SH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DIV_W-1:0]  i_div,
  input  logic [1:0]        i_mode,
  output logic              o_ad_clk,
  input  logic [DATA_W-1:0] i_ad_data,
  output logic              o_da_clk,
  output logic [DATA_W-1:0] o_da_data,
  output logic [DATA_W-1:0] o_sample,
  output logic              o_sample_valid,
  output logic [DATA_W-1:0] o_led
);

  logic                w_fall;
  logic                r_cap;
  logic                r_valid;
  logic [1:0]          r_mode;
  logic [DATA_W-1:0]   r_sample;
  logic [DATA_W-1:0]   r_da;
  logic [DATA_W-1:0]   r_ramp;
  logic [DATA_W-1:0]   r_peak;
  logic [DECAY_SH-1:0] r_decay;

  adda_clk_div #(
    .DIV_W (DIV_W)
  ) u_clk_div (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_div    (i_div),
    .o_ad_clk (o_ad_clk),
    .o_fall   (w_fall)
  );

`ifdef ADDA_AVG_EN
  logic [DATA_W-1:0] r_tap [4];
  logic              r_avg_go;
  logic [DATA_W+1:0] w_sum;
  logic [DATA_W-1:0] w_avg;

  assign w_sum = {2'b00, r_tap[0]} + {2'b00, r_tap[1]}
               + {2'b00, r_tap[2]} + {2'b00, r_tap[3]};
  assign w_avg = w_sum[DATA_W+1:2];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tap[0] <= '0;
      r_tap[1] <= '0;
      r_tap[2] <= '0;
      r_tap[3] <= '0;
      r_avg_go <= 1'b0;
    end else begin
      r_avg_go <= r_cap;
      if (r_cap) begin
        r_tap[0] <= r_sample;
        r_tap[1] <= r_tap[0];
        r_tap[2] <= r_tap[1];
        r_tap[3] <= r_tap[2];
      end
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cap    <= 1'b0;
      r_valid  <= 1'b0;
      r_mode   <= MODE_PASS;
      r_sample <= '0;
      r_da     <= '0;
      r_ramp   <= '0;
      r_peak   <= '0;
      r_decay  <= '0;
    end else begin
      r_cap   <= w_fall;
      r_valid <= r_cap;

      if (w_fall) begin
        r_sample <= i_ad_data;
        r_mode   <= i_mode;
      end

      if (r_cap) begin
        case (r_mode)
`ifndef ADDA_AVG_EN
          MODE_PASS: r_da <= r_sample;
          MODE_INV:  r_da <= ~r_sample;
`endif
          MODE_RAMP: begin
            r_da   <= r_ramp;
            r_ramp <= r_ramp + 1'b1;
          end
          default: ;
        endcase

        // A new maximum always beats a decay step landing on the same capture.
        if (r_sample > r_peak) begin
          r_peak  <= r_sample;
          r_decay <= '0;
        end else begin
          r_decay <= r_decay + 1'b1;
          if ((r_decay == '1) && (r_peak != '0)) begin
            r_peak <= r_peak - 1'b1;
          end
        end
      end

`ifdef ADDA_AVG_EN
      if (r_avg_go) begin
        if (r_mode == MODE_PASS) begin
          r_da <= w_avg;
        end else if (r_mode == MODE_INV) begin
          r_da <= ~w_avg;
        end
      end
`endif
    end
  end

  assign o_da_clk       = ~o_ad_clk;
  assign o_da_data      = r_da;
  assign o_sample       = r_sample;
  assign o_sample_valid = r_valid;
  assign o_led          = r_peak;

endmodule

`default_nettype wire

// File: tb/tb_adda_stream_ctrl.sv
// ============================================================================
// Module      : tb_adda_stream_ctrl
// Description : Directed self-checking bench for adda_stream_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adda_stream_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] i_div = 8'd0;
  logic [1:0] i_mode = 2'd0;
  logic [7:0] i_ad_data = 8'd0;
  logic       o_ad_clk;
  logic       o_da_clk;
  logic [7:0] o_da_data;
  logic [7:0] o_sample;
  logic       o_sample_valid;
  logic [7:0] o_led;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] adc;
    logic [7:0] e_da;
    logic [7:0] e_led;
  } vec_t;

  vec_t tbl [7];

  adda_stream_ctrl dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_div          (i_div),
    .i_mode         (i_mode),
    .o_ad_clk       (o_ad_clk),
    .i_ad_data      (i_ad_data),
    .o_da_clk       (o_da_clk),
    .o_da_data      (o_da_data),
    .o_sample       (o_sample),
    .o_sample_valid (o_sample_valid),
    .o_led          (o_led)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [7:0] div);
    i_reset = 1'b1;
    i_div   = div;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge i_clk);
      if (o_sample_valid === 1'b1) return;
    end
    chk({name, " valid timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        prev;
    int          cnt;
    logic [10:0] tr;
    bit          found;

    // mode, adc, expected dac, expected peak
    tbl[0] = '{2'd0, 8'h5A, 8'h5A, 8'h5A};
    tbl[1] = '{2'd0, 8'h5A, 8'h5A, 8'h5A};
    tbl[2] = '{2'd1, 8'h0F, 8'hF0, 8'h5A};
    tbl[3] = '{2'd1, 8'hA5, 8'h5A, 8'hA5};
    tbl[4] = '{2'd3, 8'h33, 8'h5A, 8'hA5};
    tbl[5] = '{2'd0, 8'h00, 8'h00, 8'hA5};
    tbl[6] = '{2'd0, 8'hFF, 8'hFF, 8'hFF};

    // Reset state
    repeat (3) @(negedge i_clk);
    chk("rst ad_clk", {31'd0, o_ad_clk}, 32'd0);
    chk("rst da_clk", {31'd0, o_da_clk}, 32'd1);
    chk("rst da_data", {24'd0, o_da_data}, 32'd0);
    chk("rst sample", {24'd0, o_sample}, 32'd0);
    chk("rst valid", {31'd0, o_sample_valid}, 32'd0);
    chk("rst led", {24'd0, o_led}, 32'd0);

    // i_div=0: toggle every cycle, DAC clock complementary
    i_reset = 1'b0;
    prev = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge i_clk);
      chk("div0 toggle", {30'd0, o_ad_clk, o_da_clk}, {30'd0, ~prev, prev});
      prev = o_ad_clk;
    end

    // i_div=3: pulse spacing, width, pass-through value
    i_mode = 2'd0;
    i_ad_data = 8'h5A;
    do_reset(8'd3);
    wait_valid("div3 first", 40);
    chk("div3 da", {24'd0, o_da_data}, 32'h5A);
    @(negedge i_clk);
    chk("valid width", {31'd0, o_sample_valid}, 32'd0);
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      cnt++;
      if (o_sample_valid === 1'b1) break;
    end
    chk("valid period", cnt, 32'd8);

    // Table-driven mode/peak vectors
    do_reset(8'd3);
    for (int i = 0; i < 7; i++) begin
      i_mode    = tbl[i].mode;
      i_ad_data = tbl[i].adc;
      wait_valid("table", 40);
      chk($sformatf("vec%0d sample", i), {24'd0, o_sample}, {24'd0, tbl[i].adc});
      chk($sformatf("vec%0d da", i), {24'd0, o_da_data}, {24'd0, tbl[i].e_da});
      chk($sformatf("vec%0d led", i), {24'd0, o_led}, {24'd0, tbl[i].e_led});
    end

    // Ramp pattern wraps after 256 captures
    i_mode = 2'd2;
    do_reset(8'd0);
    for (int r = 0; r < 257; r++) begin
      wait_valid("ramp", 10);
      chk($sformatf("ramp %0d", r), {24'd0, o_da_data}, r & 32'hFF);
    end

    // Peak hold and decay
    i_mode = 2'd0;
    i_ad_data = 8'hC0;
    do_reset(8'd0);
    wait_valid("peak", 10);
    chk("peak capture", {24'd0, o_led}, 32'hC0);
    i_ad_data = 8'h10;
    for (int k = 0; k < 15; k++) wait_valid("peak", 10);
    chk("peak hold 15", {24'd0, o_led}, 32'hC0);
    chk("peak sample", {24'd0, o_sample}, 32'h10);
    wait_valid("peak", 10);
    chk("peak decay 16", {24'd0, o_led}, 32'hBF);

    // i_div change while the high half is running
    do_reset(8'd3);
    prev = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (o_ad_clk && !prev) begin
        found = 1'b1;
        break;
      end
      prev = o_ad_clk;
    end
    chk("rise found", {31'd0, found}, 32'd1);
    i_div = 8'd1;
    tr = '0;
    for (int k = 0; k < 11; k++) begin
      @(negedge i_clk);
      tr = {tr[9:0], o_ad_clk};
    end
    chk("div change trace", {21'd0, tr}, {21'd0, 11'b11100110011});

    // Reset mid-period
    i_mode = 2'd0;
    i_ad_data = 8'h77;
    do_reset(8'd3);
    wait_valid("midrst", 40);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("midrst state", {o_ad_clk, o_sample_valid, o_sample, o_da_data, o_led, 6'd0},
        32'd0);
    i_reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge i_clk);
      if (o_sample_valid === 1'b1) cnt++;
    end
    chk("midrst no pulse", cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
